// File: rtl/vdp_io_port_pkg.sv
// Shared types for the VDP host port: command codes and read-ahead FSM states.
package vdp_io_port_pkg;

  // Command code carried in bits [7:6] of the second control byte.
  typedef enum logic [1:0] {
    CodeVramRd = 2'd0,
    CodeVramWr = 2'd1,
    CodeRegWr  = 2'd2,
    CodeCramWr = 2'd3
  } code_e;

  // Read-ahead sequencer: present address, then capture VRAM data one cycle later.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRdIssue = 2'd1,
    StRdCap   = 2'd2
  } rd_state_e;

  // True when a register index addresses an implemented register.
  function automatic logic reg_idx_valid(input logic [3:0] idx, input int unsigned num_regs);
    return 32'(idx) < num_regs;
  endfunction

endpackage

// File: rtl/vdp_io_port.sv
// VDP host port: decodes control/data port strobes into VRAM, CRAM and register writes,
// and keeps a one-byte read-ahead buffer filled from VRAM.
module vdp_io_port
  import vdp_io_port_pkg::*;
#(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned CRAM_AW  = 6,
  parameter int unsigned NUM_REGS = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_wr,
  input  logic              data_wr,
  input  logic              data_rd,
  input  logic [7:0]        host_di,
  output logic [7:0]        host_do,
  output logic              busy,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_di,
  output logic              vram_we,
  input  logic [7:0]        vram_do,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [7:0]        cram_di,
  output logic              cram_we,
  output logic [3:0]        reg_idx,
  output logic [7:0]        reg_val,
  output logic              reg_we
);

  localparam int unsigned HiW = ADDR_W - 8;

  rd_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  code_e              code_q, code_d;
  logic               first_byte_q, first_byte_d;
  logic [7:0]         byte1_q, byte1_d;
  logic [7:0]         read_buf_q, read_buf_d;

  logic [ADDR_W-1:0]  vram_addr_q, vram_addr_d;
  logic [7:0]         vram_di_q, vram_di_d;
  logic               vram_we_q, vram_we_d;
  logic [CRAM_AW-1:0] cram_addr_q, cram_addr_d;
  logic [7:0]         cram_di_q, cram_di_d;
  logic               cram_we_q, cram_we_d;
  logic [3:0]         reg_idx_q, reg_idx_d;
  logic [7:0]         reg_val_q, reg_val_d;
  logic               reg_we_q, reg_we_d;

  logic [ADDR_W-1:0]  addr_inc;
  logic [ADDR_W-1:0]  addr_new;

  assign addr_inc = addr_q + 1'b1;
  // The first control byte is held aside and only committed to the address on the second byte,
  // so a command abandoned by a data access leaves the address untouched.
  assign addr_new = {host_di[HiW-1:0], byte1_q};

  // Next-state decode of host strobes and read-ahead sequencing.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    code_d       = code_q;
    first_byte_d = first_byte_q;
    byte1_d      = byte1_q;
    read_buf_d   = read_buf_q;
    vram_addr_d  = vram_addr_q;
    vram_di_d    = vram_di_q;
    vram_we_d    = 1'b0;
    cram_addr_d  = cram_addr_q;
    cram_di_d    = cram_di_q;
    cram_we_d    = 1'b0;
    reg_idx_d    = reg_idx_q;
    reg_val_d    = reg_val_q;
    reg_we_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ctrl_wr) begin
          if (first_byte_q) begin
            byte1_d      = host_di;
            first_byte_d = 1'b0;
          end else begin
            addr_d       = addr_new;
            code_d       = code_e'(host_di[7:6]);
            first_byte_d = 1'b1;
            case (code_e'(host_di[7:6]))
              CodeVramRd: begin
                vram_addr_d = addr_new;
                state_d     = StRdIssue;
              end
              CodeRegWr: begin
                if (reg_idx_valid(host_di[3:0], NUM_REGS)) begin
                  reg_we_d  = 1'b1;
                  reg_idx_d = host_di[3:0];
                  reg_val_d = byte1_q;
                end
              end
              default: ;
            endcase
          end
        end else if (data_wr) begin
          first_byte_d = 1'b1;
          read_buf_d   = host_di;
          addr_d       = addr_inc;
          if (code_q == CodeCramWr) begin
            cram_we_d   = 1'b1;
            cram_addr_d = addr_q[CRAM_AW-1:0];
            cram_di_d   = host_di;
          end else begin
            vram_we_d   = 1'b1;
            vram_addr_d = addr_q;
            vram_di_d   = host_di;
          end
        end else if (data_rd) begin
          first_byte_d = 1'b1;
          addr_d       = addr_inc;
          vram_addr_d  = addr_inc;
          state_d      = StRdIssue;
        end
      end
      // VRAM samples vram_addr at the end of this cycle.
      StRdIssue: state_d = StRdCap;
      StRdCap: begin
        read_buf_d = vram_do;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      code_q       <= CodeVramRd;
      first_byte_q <= 1'b1;
      byte1_q      <= '0;
      read_buf_q   <= '0;
      vram_addr_q  <= '0;
      vram_di_q    <= '0;
      vram_we_q    <= 1'b0;
      cram_addr_q  <= '0;
      cram_di_q    <= '0;
      cram_we_q    <= 1'b0;
      reg_idx_q    <= '0;
      reg_val_q    <= '0;
      reg_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      code_q       <= code_d;
      first_byte_q <= first_byte_d;
      byte1_q      <= byte1_d;
      read_buf_q   <= read_buf_d;
      vram_addr_q  <= vram_addr_d;
      vram_di_q    <= vram_di_d;
      vram_we_q    <= vram_we_d;
      cram_addr_q  <= cram_addr_d;
      cram_di_q    <= cram_di_d;
      cram_we_q    <= cram_we_d;
      reg_idx_q    <= reg_idx_d;
      reg_val_q    <= reg_val_d;
      reg_we_q     <= reg_we_d;
    end
  end

  assign host_do   = read_buf_q;
  assign busy      = (state_q != StIdle);
  assign vram_addr = vram_addr_q;
  assign vram_di   = vram_di_q;
  assign vram_we   = vram_we_q;
  assign cram_addr = cram_addr_q;
  assign cram_di   = cram_di_q;
  assign cram_we   = cram_we_q;
  assign reg_idx   = reg_idx_q;
  assign reg_val   = reg_val_q;
  assign reg_we    = reg_we_q;

endmodule
